// File: rtl/lc3_memory_if.sv
// LC-3 memory bus interface.
// Groups the request/response signals between the initiator (master)
// and the wait-state memory (slave).
interface lc3_memory_if;
  logic        memEN;
  logic        memWE_out;
  logic [15:0] memory_addr;
  logic [15:0] memory_din;
  logic [15:0] memory_dout;
  logic        memRDY;
  logic        mem_fault;

  modport master (
    output memEN,
    output memWE_out,
    output memory_addr,
    output memory_din,
    input  memory_dout,
    input  memRDY,
    input  mem_fault
  );

  modport slave (
    input  memEN,
    input  memWE_out,
    input  memory_addr,
    input  memory_din,
    output memory_dout,
    output memRDY,
    output mem_fault
  );
endinterface

// File: rtl/lc3_memory.sv
// LC-3 word memory with programmable wait states.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles in WAIT (aborted
// if memEN drops), then spends one cycle in DONE with memRDY high. Reads
// load memory_dout on entry to DONE; writes commit at the edge that ends
// DONE. Address bits above ADDR_WIDTH-1 alias.
// Optional feature macro: LC3_MEMORY_WRITE_PROTECT_EN -- writes below
// PROTECT_LIMIT are dropped and set the sticky mem_fault flag.
module lc3_memory #(
  parameter int unsigned WAIT_CYCLES   = 3,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter logic [15:0] PROTECT_LIMIT = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  lc3_memory_if.slave bus
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             din_q, din_d;
  logic                    we_q, we_d;
  logic [15:0]             dout_q, dout_d;
  logic                    rdy_q, rdy_d;
  logic                    fault_q, fault_d;
  logic                    protect_s;
  logic                    wr_commit_s;

  // Storage array; deliberately never reset or initialised.
  logic [15:0] mem_q [DEPTH];

  // Upper address bits are ignored when the array is narrower than the bus.
  if (ADDR_WIDTH < 16) begin : g_alias
    logic unused_addr_s;
    assign unused_addr_s = ^bus.memory_addr[15:ADDR_WIDTH];
  end

`ifdef LC3_MEMORY_WRITE_PROTECT_EN
  // Writes to the low region are refused (compared on the aliased address).
  assign protect_s = (32'(addr_q) < 32'(PROTECT_LIMIT));
`else
  assign protect_s = 1'b0;
`endif

  // A write lands only at the end of the DONE cycle of a write transaction.
  assign wr_commit_s = (state_q == DONE) && we_q && !protect_s;

  // Next-state, transaction capture and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = we_q;
    dout_d  = dout_q;
    rdy_d   = 1'b0;
    fault_d = fault_q;

    case (state_q)
      IDLE: begin
        if (bus.memEN) begin
          addr_d = bus.memory_addr[ADDR_WIDTH-1:0];
          din_d  = bus.memory_din;
          we_d   = bus.memWE_out;
          cnt_d  = WAIT_LOAD;
          if (WAIT_LOAD == 4'd0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!bus.memEN) begin
          // Initiator withdrew: drop the transaction without side effects.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // DONE is only ever entered from IDLE/WAIT, so this fires once per access.
    if (state_d == DONE) begin
      rdy_d = 1'b1;
      if (!we_d) begin
        dout_d = mem_q[addr_d];
      end else begin
        dout_d = dout_q;
      end
    end else begin
      rdy_d = 1'b0;
    end

    if ((state_q == DONE) && we_q && protect_s) begin
      fault_d = 1'b1;
    end else begin
      fault_d = fault_q;
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      din_q   <= 16'h0000;
      we_q    <= 1'b0;
      dout_q  <= 16'h0000;
      rdy_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      fault_q <= fault_d;
    end
  end

  // Array write port; outside the reset domain so reset never alters contents.
  always_ff @(posedge clk) begin
    if (wr_commit_s) begin
      mem_q[addr_q] <= din_q;
    end
  end

  assign bus.memory_dout = dout_q;
  assign bus.memRDY      = rdy_q;
  assign bus.mem_fault   = fault_q;

endmodule

// File: tb/tb_lc3_memory.sv
// Testbench for lc3_memory: two instances (WAIT_CYCLES=3/ADDR_WIDTH=16 and
// WAIT_CYCLES=0/ADDR_WIDTH=12) driven by directed and random transactions,
// checked every cycle against a transaction-level model of the memory.
module tb_lc3_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s  [2];
  logic        en_s   [2];
  logic        we_s   [2];
  logic [15:0] addr_s [2];
  logic [15:0] din_s  [2];
  logic [15:0] dout_s [2];
  logic        rdy_s  [2];
  logic        fault_s[2];

  lc3_memory_if bus0 ();
  lc3_memory_if bus1 ();

  assign bus0.memEN       = en_s[0];
  assign bus0.memWE_out   = we_s[0];
  assign bus0.memory_addr = addr_s[0];
  assign bus0.memory_din  = din_s[0];
  assign dout_s[0]        = bus0.memory_dout;
  assign rdy_s[0]         = bus0.memRDY;
  assign fault_s[0]       = bus0.mem_fault;

  assign bus1.memEN       = en_s[1];
  assign bus1.memWE_out   = we_s[1];
  assign bus1.memory_addr = addr_s[1];
  assign bus1.memory_din  = din_s[1];
  assign dout_s[1]        = bus1.memory_dout;
  assign rdy_s[1]         = bus1.memRDY;
  assign fault_s[1]       = bus1.mem_fault;

  lc3_memory #(.WAIT_CYCLES(3), .ADDR_WIDTH(16), .PROTECT_LIMIT(16'h3000)) dut0 (
    .clk (clk),
    .rst (rst_s[0]),
    .bus (bus0)
  );

  lc3_memory #(.WAIT_CYCLES(0), .ADDR_WIDTH(12), .PROTECT_LIMIT(16'h3000)) dut1 (
    .clk (clk),
    .rst (rst_s[1]),
    .bus (bus1)
  );

  // ---------------- model state ----------------
  int          wc   [2] = '{3, 0};
  logic [15:0] mask [2] = '{16'hFFFF, 16'h0FFF};
  int          cyc = 0;
  int          due [2] = '{-1, -1};
  logic        pend_we  [2];
  logic [15:0] pend_addr[2];
  logic [15:0] pend_din [2];
  logic [15:0] exp_dout [2] = '{16'h0000, 16'h0000};
  logic        dknown   [2] = '{1'b1, 1'b1};
  logic        exp_fault[2] = '{1'b0, 1'b0};
  int          rdy_cyc  [2];
  logic [15:0] mdl [int];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int mkey(input int k, input logic [15:0] a);
    return k * 65536 + int'(a & mask[k]);
  endfunction

  function automatic logic is_protected(input int k, input logic [15:0] a);
`ifdef LC3_MEMORY_WRITE_PROTECT_EN
    return ((a & mask[k]) < 16'h3000);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison of every DUT output against the model.
  always begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_s[k]) begin
        exp_dout[k]  = 16'h0000;
        dknown[k]    = 1'b1;
        exp_fault[k] = 1'b0;
        due[k]       = -1;
      end else if (cyc == due[k]) begin
        if (!pend_we[k]) begin
          if (mdl.exists(mkey(k, pend_addr[k]))) begin
            exp_dout[k] = mdl[mkey(k, pend_addr[k])];
            dknown[k]   = 1'b1;
          end else begin
            dknown[k]   = 1'b0;
          end
        end else if (is_protected(k, pend_addr[k])) begin
          exp_fault[k] = 1'b1;
        end else begin
          mdl[mkey(k, pend_addr[k])] = pend_din[k];
        end
      end
      chk($sformatf("dut%0d memRDY", k), 32'(rdy_s[k]), 32'(rst_s[k] && (cyc == due[k])));
      if (dknown[k]) chk($sformatf("dut%0d memory_dout", k), 32'(dout_s[k]), 32'(exp_dout[k]));
      chk($sformatf("dut%0d mem_fault", k), 32'(fault_s[k]), 32'(exp_fault[k]));
      if (cyc == due[k]) due[k] = -1;
    end
  end

  // One transaction; called at a negedge with the DUT idle, returns at a
  // negedge with the DUT idle. abort_at/rst_at (1..) withdraw memEN or
  // pulse reset at that negedge after accept.
  task automatic txn(input int k, input logic we, input logic [15:0] a, input logic [15:0] d,
                     input int abort_at, input int rst_at,
                     output logic [15:0] obs, output int lat);
    obs = 16'h0000;
    lat = 0;
    we_s[k] = we; addr_s[k] = a; din_s[k] = d; en_s[k] = 1'b1;
    pend_we[k] = we; pend_addr[k] = a; pend_din[k] = d;
    due[k] = cyc + 1 + wc[k];
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      we_s[k] = 1'($urandom); addr_s[k] = 16'($urandom); din_s[k] = 16'($urandom);
      if (n == abort_at) begin
        en_s[k] = 1'b0;
        due[k]  = -1;
        break;
      end
      if (n == rst_at) begin
        rst_s[k] = 1'b0;
        en_s[k]  = 1'b0;
        due[k]   = -1;
        @(negedge clk);
        chk("reset rdy", 32'(rdy_s[k]), 32'h0);
        chk("reset dout", 32'(dout_s[k]), 32'h0);
        chk("reset fault", 32'(fault_s[k]), 32'h0);
        rst_s[k] = 1'b1;
        break;
      end
      if (rdy_s[k] === 1'b1) begin
        lat        = n;
        obs        = dout_s[k];
        rdy_cyc[k] = cyc;
        en_s[k]    = 1'($urandom);
        break;
      end
    end
    if (abort_at == 0 && rst_at == 0) chk("completion seen", 32'(lat != 0), 32'h1);
    @(negedge clk);
    en_s[k] = 1'b0;
  endtask

  function automatic logic [15:0] rnd_addr(input int k);
    logic [15:0] a;
    a = (($urandom_range(0, 1) == 1) ? 16'h3000 : 16'h0100) + 16'($urandom_range(0, 7));
    if (k == 1) a[15:12] = 4'($urandom);
    return a;
  endfunction

  initial begin
    logic [15:0] obs;
    int          lat;
    int          first_rdy;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b0; en_s[k] = 1'b0; we_s[k] = 1'b0;
      addr_s[k] = 16'h0000; din_s[k] = 16'h0000;
    end
    repeat (3) @(negedge clk);
    chk("por rdy", 32'(rdy_s[0]), 32'h0);
    chk("por dout", 32'(dout_s[0]), 32'h0);
    chk("por fault", 32'(fault_s[0]), 32'h0);
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    @(negedge clk);

    // Write then read back with 3 wait states.
    txn(0, 1'b1, 16'h3000, 16'hBEEF, 0, 0, obs, lat);
    chk("write latency", 32'(lat), 32'd4);
    txn(0, 1'b0, 16'h3000, 16'h0000, 0, 0, obs, lat);
    chk("read latency", 32'(lat), 32'd4);
    chk("read BEEF", 32'(obs), 32'h0000BEEF);

    // Abort two cycles into a write.
    txn(0, 1'b1, 16'h4000, 16'h7777, 0, 0, obs, lat);
    txn(0, 1'b1, 16'h4000, 16'hDEAD, 2, 0, obs, lat);
    chk("abort no rdy", 32'(lat), 32'd0);
    txn(0, 1'b0, 16'h4000, 16'h0000, 0, 0, obs, lat);
    chk("abort keeps old", 32'(obs), 32'h00007777);

    // Reset in the middle of a write.
    txn(0, 1'b1, 16'h5000, 16'h4321, 0, 0, obs, lat);
    txn(0, 1'b1, 16'h5000, 16'h1234, 0, 2, obs, lat);
    txn(0, 1'b0, 16'h5000, 16'h0000, 0, 0, obs, lat);
    chk("reset drops write", 32'(obs), 32'h00004321);

    // Write into the low region.
    txn(0, 1'b1, 16'h0100, 16'hAAAA, 0, 0, obs, lat);
    chk("low write rdy", 32'(lat), 32'd4);
    txn(0, 1'b0, 16'h0100, 16'h0000, 0, 0, obs, lat);
`ifdef LC3_MEMORY_WRITE_PROTECT_EN
    chk("protect fault", 32'(fault_s[0]), 32'h1);
`else
    chk("low write data", 32'(obs), 32'h0000AAAA);
    chk("no fault", 32'(fault_s[0]), 32'h0);
`endif

    // Zero wait states, back-to-back accesses, 12-bit aliasing.
    txn(1, 1'b1, 16'h3001, 16'h1111, 0, 0, obs, lat);
    txn(1, 1'b1, 16'h3002, 16'h2222, 0, 0, obs, lat);
    txn(1, 1'b0, 16'h3001, 16'h0000, 0, 0, obs, lat);
    chk("w0 latency", 32'(lat), 32'd1);
    first_rdy = rdy_cyc[1];
`ifndef LC3_MEMORY_WRITE_PROTECT_EN
    chk("b2b first", 32'(obs), 32'h00001111);
`endif
    txn(1, 1'b0, 16'h3002, 16'h0000, 0, 0, obs, lat);
    chk("b2b spacing", 32'(rdy_cyc[1] - first_rdy), 32'd2);
`ifndef LC3_MEMORY_WRITE_PROTECT_EN
    chk("b2b second", 32'(obs), 32'h00002222);
`endif
    txn(1, 1'b1, 16'h1ABC, 16'h5555, 0, 0, obs, lat);
    txn(1, 1'b0, 16'h0ABC, 16'h0000, 0, 0, obs, lat);
`ifdef LC3_MEMORY_WRITE_PROTECT_EN
    chk("alias fault", 32'(fault_s[1]), 32'h1);
`else
    chk("alias read", 32'(obs), 32'h00005555);
`endif

    // Random traffic on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 150; t++) begin
        int ab;
        ab = 0;
        if (wc[k] > 0 && $urandom_range(0, 7) == 0) ab = $urandom_range(1, wc[k]);
        txn(k, 1'($urandom), rnd_addr(k), 16'($urandom), ab, 0, obs, lat);
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 3)) begin
            addr_s[k] = 16'($urandom);
            @(negedge clk);
          end
        end
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lc3_memory.md
LC3_MEMORY -- requirements
Module: lc3_memory

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be on the rising edge of clk.
REQ-002 Parameter WAIT_CYCLES, default 3: number of wait states inserted before each completion; legal range 0..15.
REQ-003 Parameter ADDR_WIDTH, default 16: storage depth is 2^ADDR_WIDTH words; address bits above ADDR_WIDTH-1 SHALL be ignored (aliasing).
REQ-004 Parameter PROTECT_LIMIT, default 16'h3000: the first unprotected address (see Configuration).
REQ-005 Port: clk  input  1  system clock.
REQ-006 Port: rst  input  1  asynchronous active-low reset.
REQ-007 Port: memEN  input  1  request; high while the initiator wants an access.
REQ-008 Port: memWE_out  input  1  1 = write, 0 = read; sampled at accept.
REQ-009 Port: memory_addr  input  16  word address; sampled at accept.
REQ-010 Port: memory_din  input  16  write data; sampled at accept.
REQ-011 Port: memory_dout  output  16  read data, registered.
REQ-012 Port: memRDY  output  1  one-cycle completion strobe (the R signal).
REQ-013 Port: mem_fault  output  1  sticky protection-fault flag.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-015 IDLE: on a clock edge with memEN=1, latch address, write data and memWE_out, load wait counter with WAIT_CYCLES, then go to WAIT (or DONE if WAIT_CYCLES=0).
REQ-016 WAIT: decrement the counter each cycle; go to DONE when it reaches 0 with memEN still high.
REQ-017 If memEN=0 on any edge in WAIT, the transaction SHALL abort: return to IDLE, no write, no memRDY, memory_dout unchanged.
REQ-018 DONE: assert memRDY for exactly one cycle, then return to IDLE unconditionally; memEN is ignored in DONE.
REQ-019 Latency: memRDY SHALL be high in the (WAIT_CYCLES+1)th cycle after the accept edge.
REQ-020 A read SHALL drive the addressed word onto memory_dout during the memRDY cycle; memory_dout SHALL hold that value until the next completed read.
REQ-021 A write SHALL update the array at the edge that ends the memRDY cycle; a write SHALL leave memory_dout unchanged.
REQ-022 memEN high in the cycle after memRDY SHALL be accepted as a new transaction, so back-to-back accesses are legal.
REQ-023 Input changes after accept SHALL NOT affect the transaction in flight.
REQ-024 Array contents SHALL be uninitialised; this block provides no reset or initialisation path for them.

Reset
REQ-025 While rst=0: state IDLE, counter 0, memRDY=0, memory_dout=16'h0000, mem_fault=0.
REQ-026 Reset asserted mid-transaction SHALL drop the transaction; a pending write SHALL NOT reach the array.
REQ-027 Reset SHALL NOT alter array contents.

Configuration
REQ-028 Macro LC3_MEMORY_WRITE_PROTECT_EN, when defined: a write to an address below PROTECT_LIMIT SHALL complete normally with memRDY, leave the array unchanged, and set mem_fault; mem_fault SHALL clear only on reset.
REQ-029 Without LC3_MEMORY_WRITE_PROTECT_EN: all writes SHALL update the array, and mem_fault SHALL be constant 0.
REQ-030 Reads SHALL be unaffected by the macro in both builds.

Verification
REQ-031 WAIT_CYCLES=3: write x3000<-xBEEF, then read x3000 -> memRDY exactly 4 cycles after each accept; memory_dout=xBEEF in the read memRDY cycle.
REQ-032 WAIT_CYCLES=0: back-to-back reads of x3001 and x3002 holding x1111 and x2222 -> memRDY on consecutive-but-one cycles; memory_dout = x1111, then x2222.
REQ-033 Drop memEN 2 cycles into a write of xDEAD to x4000 (WAIT_CYCLES=3) -> no memRDY; a later read of x4000 returns its prior value.
REQ-034 Assert rst during WAIT of a write x5000<-x1234 -> memRDY, memory_dout and mem_fault are 0; x5000 is unchanged.
REQ-035 With macro defined: write x0100<-xAAAA -> memRDY pulses, mem_fault=1 and stays 1; reading x0100 returns the old value. Without the macro: the same write reads back xAAAA and mem_fault=0.
REQ-036 ADDR_WIDTH=12: write x1ABC<-x5555, then read x0ABC -> x5555 (alias).
